mips_hazard_scoreboard: RTL and testbench
=========================================

MIPS_HAZARD_SCOREBOARD -- requirements
Module: mips_hazard_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32: width of operand and result data.
REQ-002 Parameter REG_ID_W, default 5: register id width. Register 0 is hardwired zero.
REQ-003 Parameter DEPTH, default 4: number of in-flight slots, counting issue to register-file write.
REQ-004 Parameter NUM_READ, default 2: number of operand read ports checked each cycle.
REQ-005 Parameter LAT_W, default $clog2(DEPTH+1): width of the latency field.
REQ-006 clk  in  1  Single clock; all state updates on posedge clk.
REQ-007 rst  in  1  Synchronous, active-high reset.
REQ-008 issue_valid  in  1  An instruction in ID requests issue this cycle.
REQ-009 issue_wr_en  in  1  The issuing instruction writes a register.
REQ-010 issue_wr_id  in  REG_ID_W  Destination register id.
REQ-011 issue_lat  in  LAT_W  Result-ready age, 1..DEPTH (ALU op = 1, load = 2).
REQ-012 issue_kill  in  1  Squash the issuing instruction (branch/jump redirect).
REQ-013 rd_id  in  NUM_READ*REG_ID_W  Source register ids, port p at bits [p*REG_ID_W +: REG_ID_W].
REQ-014 rd_used  in  NUM_READ  Per-port flag: the operand is actually consumed.
REQ-015 stage_data  in  DEPTH*DATA_W  Result for slot s (age s) at bits [(s-1)*DATA_W +: DATA_W].
REQ-016 stall  out  1  Hold the IF and ID stages; a bubble is inserted.
REQ-017 fwd_hit  out  NUM_READ  Per-port flag: use fwd_data instead of the register-file output.
REQ-018 fwd_data  out  NUM_READ*DATA_W  Forwarded operand per port.
REQ-019 retire_valid / retire_id  out  1 / REG_ID_W  Contents of slot DEPTH: the register-file write this cycle.
REQ-020 stall_count  out  16  Saturating count of stalled cycles.

Function
REQ-021 Each slot s in 1..DEPTH shall hold {valid, id, lat}. Slot s holds the instruction issued s cycles ago.
REQ-022 Every posedge: slot[s+1] <= slot[s] for s = 1..DEPTH-1, and slot DEPTH is discarded. The shift occurs unconditionally, including stall cycles.
REQ-023 Slot 1 shall load {1, issue_wr_id, issue_lat} only when issue_valid & issue_wr_en & !stall & !issue_kill & issue_wr_id != 0. Otherwise slot 1 loads valid = 0.
REQ-024 Lookup is combinational. For each port p with rd_used[p] = 1 and rd_id[p] != 0, select the lowest s such that slot[s].valid and slot[s].id == rd_id[p] (youngest writer wins).
REQ-025 On a match with s >= slot[s].lat: fwd_hit[p] = 1 and fwd_data[p] = stage_data slot s.
REQ-026 On a match with s < slot[s].lat: the result is not ready, and stall = 1.
REQ-027 On no match, rd_id = 0, or rd_used = 0: fwd_hit[p] = 0 and fwd_data[p] = 0.
REQ-028 stall = issue_valid & (OR of all not-ready matches). stall shall never depend on issue_kill.
REQ-029 stall_count increments on every cycle with stall = 1 and saturates at 16'hFFFF.
REQ-030 Simultaneous events: a retiring slot DEPTH still forwards in its final cycle. If issue_wr_id equals a matched rd_id, the issuing instruction does not match itself.
REQ-031 DEPTH = 1 is legal: issue_lat shall be 1, so stall never asserts.
REQ-032 issue_lat = 0 or issue_lat > DEPTH is illegal input. The bench shall flag it with an assertion; the RTL treats it as DEPTH.

Reset
REQ-033 While rst = 1 at posedge, all slot valid bits shall clear and stall_count <= 0.
REQ-034 After reset, stall, fwd_hit, retire_valid, retire_id and fwd_data shall all be 0.
REQ-035 Reset applied mid-operation discards all in-flight entries with no retire pulse in the following cycle.
REQ-036 Slot id and lat fields need not be reset.

Verification
REQ-037 ALU back-to-back (DEPTH = 4): issue wr $8, lat 1, then next cycle read $8 with stage_data slot 1 = 0x1234. Required: fwd_hit[0] = 1, fwd_data = 0x1234, stall = 0.
REQ-038 Load-use: issue wr $9, lat 2, then read $9 next cycle. Required: stall = 1 for exactly 1 cycle, then fwd_hit from slot 2, and stall_count = 1.
REQ-039 Youngest wins: $10 written with lat 1 at cycles 0 and 1, read at cycle 2 with slot1 = 0xB and slot2 = 0xA. Required: fwd_data = 0xB.
REQ-040 Zero register and kill: issue wr $0, then issue wr $11 with issue_kill = 1. Reading $0 or $11 next cycle gives fwd_hit = 0, stall = 0, and no retire_valid 4 cycles later.
REQ-041 Retire/reset: issue wr $12, lat 1. retire_valid = 1 with retire_id = 12 exactly 4 cycles later. rst asserted at cycle 2 suppresses it and stall_count returns to 0.
REQ-042 Saturation: hold a not-ready match for 70000 cycles by forcing lat via repeated reissue. Required: stall_count = 16'hFFFF.

Source files
------------

// File: rtl/mips_hazard_scoreboard_if.sv
// ----------------------------------------------------------------------------
// mips_hazard_scoreboard_if
//
// Purpose: bundles the issue, operand-lookup and status signals that are
// exchanged between the ID stage (master) and the hazard scoreboard (slave).
//
// Handshake semantics: there is no valid/ready pair on this interface.
// issue_valid qualifies the issue fields for the current cycle only, and
// stall is the scoreboard's combinational answer in that same cycle. An
// instruction is accepted at the rising edge when issue_valid = 1 and
// stall = 0. While stall = 1 the master holds the instruction and presents
// it again in the next cycle.
//
// Signal summary (direction seen from the scoreboard / slave):
//   issue_valid  in   instruction in ID requests issue
//   issue_wr_en  in   issuing instruction writes a register
//   issue_wr_id  in   destination register id
//   issue_lat    in   age at which the result becomes forwardable (1..DEPTH)
//   issue_kill   in   squash the issuing instruction
//   rd_id        in   source register ids, port p at [p*REG_ID_W +: REG_ID_W]
//   rd_used      in   per-port flag: operand actually consumed
//   stage_data   in   result for age s at [(s-1)*DATA_W +: DATA_W]
//   stall        out  hold IF/ID, insert a bubble
//   fwd_hit      out  per-port forward select
//   fwd_data     out  forwarded operand per port
//   retire_valid out  slot DEPTH holds a register-file write this cycle
//   retire_id    out  register id written this cycle (0 when not valid)
//   stall_count  out  saturating count of stalled cycles
// ----------------------------------------------------------------------------
interface mips_hazard_scoreboard_if #(
    parameter int DATA_W   = 32,
    parameter int REG_ID_W = 5,
    parameter int DEPTH    = 4,
    parameter int NUM_READ = 2,
    parameter int LAT_W    = $clog2(DEPTH + 1)
);
    logic                         issue_valid;
    logic                         issue_wr_en;
    logic [REG_ID_W-1:0]          issue_wr_id;
    logic [LAT_W-1:0]             issue_lat;
    logic                         issue_kill;
    logic [NUM_READ*REG_ID_W-1:0] rd_id;
    logic [NUM_READ-1:0]          rd_used;
    logic [DEPTH*DATA_W-1:0]      stage_data;

    logic                         stall;
    logic [NUM_READ-1:0]          fwd_hit;
    logic [NUM_READ*DATA_W-1:0]   fwd_data;
    logic                         retire_valid;
    logic [REG_ID_W-1:0]          retire_id;
    logic [15:0]                  stall_count;

    // ID stage / pipeline control side
    modport master (
        output issue_valid, issue_wr_en, issue_wr_id, issue_lat, issue_kill,
        output rd_id, rd_used, stage_data,
        input  stall, fwd_hit, fwd_data, retire_valid, retire_id, stall_count
    );

    // Scoreboard side
    modport slave (
        input  issue_valid, issue_wr_en, issue_wr_id, issue_lat, issue_kill,
        input  rd_id, rd_used, stage_data,
        output stall, fwd_hit, fwd_data, retire_valid, retire_id, stall_count
    );
endinterface

// File: rtl/mips_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// mips_hazard_scoreboard
//
// Purpose: tracks in-flight register writers of a short in-order MIPS-style
// pipeline and, for each operand read port, decides between forwarding a
// result from a later stage or stalling the front end until the result
// exists.
//
// Each slot s (1..DEPTH) describes the instruction issued s cycles ago as
// {valid, id, lat}. The slots form a shift line that advances every clock,
// stall or not; a stall simply injects an invalid entry into slot 1.
// Slot DEPTH is the register-file write of the current cycle.
//
// Ports:
//   clk   single clock, all state updates on the rising edge
//   rst   synchronous, active-high reset (clears valid bits and stall_count)
//   bus   mips_hazard_scoreboard_if.slave, see the interface header
// ----------------------------------------------------------------------------
module mips_hazard_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int REG_ID_W = 5,
    parameter int DEPTH    = 4,
    parameter int NUM_READ = 2,
    parameter int LAT_W    = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    mips_hazard_scoreboard_if.slave       bus
);

    // ------------------------------------------------------------------
    // Slot storage. Array index i holds slot s = i + 1.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [REG_ID_W-1:0] id_q  [DEPTH];
    logic [REG_ID_W-1:0] id_d  [DEPTH];
    logic [LAT_W-1:0]    lat_q [DEPTH];
    logic [LAT_W-1:0]    lat_d [DEPTH];
    logic [15:0]         stall_count_q, stall_count_d;

    // Lookup results
    logic                         stall;
    logic [NUM_READ-1:0]          not_ready;
    logic [NUM_READ-1:0]          fwd_hit;
    logic [NUM_READ*DATA_W-1:0]   fwd_data;

    // Lookup scratch (fully assigned before use on every port iteration)
    logic [REG_ID_W-1:0]          look_id;
    logic                         look_found;
    int                           look_idx;

    // Issue qualification
    logic [LAT_W-1:0]             lat_eff;
    logic                         issue_load;

    // ------------------------------------------------------------------
    // Operand lookup. Scanning from the oldest slot down to slot 1 and
    // letting every match overwrite the previous one leaves the youngest
    // writer selected. The instruction currently in ID is not yet in any
    // slot, so it can never match its own source operands.
    // ------------------------------------------------------------------
    always_comb begin
        fwd_hit    = '0;
        fwd_data   = '0;
        not_ready  = '0;
        look_id    = '0;
        look_found = 1'b0;
        look_idx   = 0;
        for (int p = 0; p < NUM_READ; p++) begin
            look_id    = bus.rd_id[p*REG_ID_W +: REG_ID_W];
            look_found = 1'b0;
            look_idx   = 0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (valid_q[i] && (id_q[i] == look_id)) begin
                    look_found = 1'b1;
                    look_idx   = i;
                end
            end
            if (bus.rd_used[p] && (look_id != '0) && look_found) begin
                // Slot s = look_idx + 1 is ready once its age reaches lat.
                if (int'(lat_q[look_idx]) <= look_idx + 1) begin
                    fwd_hit[p]                    = 1'b1;
                    fwd_data[p*DATA_W +: DATA_W]  = bus.stage_data[look_idx*DATA_W +: DATA_W];
                end else begin
                    not_ready[p] = 1'b1;
                end
            end
        end
        // Deliberately independent of issue_kill: the kill arrives late in
        // the cycle and must not sit on the stall path.
        stall = bus.issue_valid & (|not_ready);
    end

    // ------------------------------------------------------------------
    // Next-state for the shift line and the stall counter.
    // ------------------------------------------------------------------
    always_comb begin
        // Out-of-range latencies are clamped to the longest pipeline age so
        // the entry is treated conservatively.
        if ((bus.issue_lat == '0) || (int'(bus.issue_lat) > DEPTH)) begin
            lat_eff = LAT_W'(DEPTH);
        end else begin
            lat_eff = bus.issue_lat;
        end

        issue_load = bus.issue_valid & bus.issue_wr_en & ~stall &
                     ~bus.issue_kill & (bus.issue_wr_id != '0);

        valid_d    = '0;
        valid_d[0] = issue_load;
        id_d[0]    = bus.issue_wr_id;
        lat_d[0]   = lat_eff;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            id_d[i]    = id_q[i-1];
            lat_d[i]   = lat_q[i-1];
        end

        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Control state: valid bits and the counter are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            stall_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Payload fields are only meaningful under a valid bit, so no reset.
    always_ff @(posedge clk) begin
        id_q  <= id_d;
        lat_q <= lat_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.stall        = stall;
    assign bus.fwd_hit      = fwd_hit;
    assign bus.fwd_data     = fwd_data;
    assign bus.retire_valid = valid_q[DEPTH-1];
    // Masked so that an unreset id field never shows up after reset.
    assign bus.retire_id    = valid_q[DEPTH-1] ? id_q[DEPTH-1] : '0;
    assign bus.stall_count  = stall_count_q;

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_mips_hazard_scoreboard
//
// Drives the scoreboard through directed scenarios and a randomized run.
// The reference model keeps a list of accepted writers stamped with the
// cycle they issued in; ages, youngest-writer selection and readiness are
// derived from those stamps.
// ----------------------------------------------------------------------------
module tb_mips_hazard_scoreboard;

    localparam int DATA_W   = 32;
    localparam int REG_ID_W = 5;
    localparam int DEPTH    = 4;
    localparam int NUM_READ = 2;
    localparam int LAT_W    = $clog2(DEPTH + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_hazard_scoreboard_if #(
        .DATA_W(DATA_W), .REG_ID_W(REG_ID_W), .DEPTH(DEPTH),
        .NUM_READ(NUM_READ), .LAT_W(LAT_W)
    ) bus ();

    mips_hazard_scoreboard #(
        .DATA_W(DATA_W), .REG_ID_W(REG_ID_W), .DEPTH(DEPTH),
        .NUM_READ(NUM_READ), .LAT_W(LAT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Illegal latencies are a stimulus error.
    always @(posedge clk) begin
        if (!rst && bus.issue_valid) begin
            assert (bus.issue_lat >= 1 && int'(bus.issue_lat) <= DEPTH)
                else $error("illegal issue_lat %0d", bus.issue_lat);
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int                  cyc;
        logic [REG_ID_W-1:0] id;
        int                  lat;
    } rec_t;

    rec_t recs[$];
    int   cyc;
    int   cnt_m;
    int   n_checks;
    int   n_pass;

    logic                       exp_stall;
    logic [NUM_READ-1:0]        exp_hit;
    logic [NUM_READ*DATA_W-1:0] exp_data;
    logic                       exp_rv;
    logic [REG_ID_W-1:0]        exp_rid;
    logic [15:0]                exp_cnt;

    function automatic void model_eval();
        logic [NUM_READ*REG_ID_W-1:0] ids;
        logic [DEPTH*DATA_W-1:0]      sd;
        logic [REG_ID_W-1:0]          rid;
        logic                         nr;
        int                           best;
        int                           blat;
        int                           age;
        ids       = bus.rd_id;
        sd        = bus.stage_data;
        exp_hit   = '0;
        exp_data  = '0;
        exp_rv    = 1'b0;
        exp_rid   = '0;
        nr        = 1'b0;
        for (int p = 0; p < NUM_READ; p++) begin
            rid = ids[p*REG_ID_W +: REG_ID_W];
            if (bus.rd_used[p] && rid != 0) begin
                best = 0;
                blat = 0;
                foreach (recs[i]) begin
                    age = cyc - recs[i].cyc;
                    if (age >= 1 && age <= DEPTH && recs[i].id == rid &&
                        (best == 0 || age < best)) begin
                        best = age;
                        blat = recs[i].lat;
                    end
                end
                if (best != 0) begin
                    if (best >= blat) begin
                        exp_hit[p] = 1'b1;
                        exp_data[p*DATA_W +: DATA_W] = sd[(best-1)*DATA_W +: DATA_W];
                    end else begin
                        nr = 1'b1;
                    end
                end
            end
        end
        exp_stall = bus.issue_valid && nr;
        foreach (recs[i]) begin
            if (cyc - recs[i].cyc == DEPTH) begin
                exp_rv  = 1'b1;
                exp_rid = recs[i].id;
            end
        end
        exp_cnt = cnt_m[15:0];
    endfunction

    // Advance one clock: commit the model at the rising edge, return at the
    // falling edge where the next inputs are driven.
    task automatic step();
        logic q;
        rec_t r;
        model_eval();
        q = bus.issue_valid && bus.issue_wr_en && !exp_stall &&
            !bus.issue_kill && bus.issue_wr_id != 0;
        @(posedge clk);
        if (rst) begin
            recs.delete();
            cnt_m = 0;
        end else begin
            if (exp_stall && cnt_m < 65535) cnt_m++;
            if (q) begin
                r.cyc = cyc;
                r.id  = bus.issue_wr_id;
                r.lat = int'(bus.issue_lat);
                recs.push_back(r);
            end
        end
        cyc++;
        while (recs.size() > 0 && cyc - recs[0].cyc > DEPTH) void'(recs.pop_front());
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.issue_wr_en = 1'b0;
        bus.issue_wr_id = '0;
        bus.issue_lat   = LAT_W'(1);
        bus.issue_kill  = 1'b0;
        bus.rd_id       = '0;
        bus.rd_used     = '0;
        bus.stage_data  = '0;
    endtask

    task automatic issue(input int id, input int lat, input logic kill);
        bus.issue_valid = 1'b1;
        bus.issue_wr_en = 1'b1;
        bus.issue_wr_id = REG_ID_W'(id);
        bus.issue_lat   = LAT_W'(lat);
        bus.issue_kill  = kill;
    endtask

    task automatic read_port(input int p, input int id);
        bus.rd_id[p*REG_ID_W +: REG_ID_W] = REG_ID_W'(id);
        bus.rd_used[p] = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        bus.issue_valid = 1'b1;
        read_port(0, 8);
        read_port(1, 9);
        #1;
        n_checks++; if (bus.stall !== 1'b0) $display("FAIL reset_stall got %b want 0", bus.stall); else n_pass++;
        n_checks++; if (bus.fwd_hit !== '0) $display("FAIL reset_fwd_hit got %b want 0", bus.fwd_hit); else n_pass++;
        n_checks++; if (bus.fwd_data !== '0) $display("FAIL reset_fwd_data got %h want 0", bus.fwd_data); else n_pass++;
        n_checks++; if (bus.retire_valid !== 1'b0) $display("FAIL reset_retire_valid got %b want 0", bus.retire_valid); else n_pass++;
        n_checks++; if (bus.retire_id !== '0) $display("FAIL reset_retire_id got %0d want 0", bus.retire_id); else n_pass++;
        n_checks++; if (bus.stall_count !== 16'h0) $display("FAIL reset_stall_count got %0d want 0", bus.stall_count); else n_pass++;
        idle();
        step();
    endtask

    task automatic test_alu_back_to_back();
        do_reset();
        issue(8, 1, 1'b0);
        step();
        idle();
        bus.issue_valid = 1'b1;
        read_port(0, 8);
        bus.stage_data = {$urandom(), $urandom(), $urandom(), 32'h1234};
        #1;
        n_checks++; if (bus.fwd_hit[0] !== 1'b1) $display("FAIL alu_fwd_hit got %b want 1", bus.fwd_hit[0]); else n_pass++;
        n_checks++; if (bus.fwd_data[31:0] !== 32'h1234) $display("FAIL alu_fwd_data got %h want 00001234", bus.fwd_data[31:0]); else n_pass++;
        n_checks++; if (bus.stall !== 1'b0) $display("FAIL alu_stall got %b want 0", bus.stall); else n_pass++;
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        issue(9, 2, 1'b0);
        step();
        idle();
        bus.issue_valid = 1'b1;
        read_port(0, 9);
        bus.stage_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        #1;
        n_checks++; if (bus.stall !== 1'b1) $display("FAIL load_use_stall1 got %b want 1", bus.stall); else n_pass++;
        step();
        bus.stage_data = {$urandom(), $urandom(), 32'h5678, $urandom()};
        #1;
        n_checks++; if (bus.stall !== 1'b0) $display("FAIL load_use_stall2 got %b want 0", bus.stall); else n_pass++;
        n_checks++; if (bus.fwd_hit[0] !== 1'b1) $display("FAIL load_use_hit got %b want 1", bus.fwd_hit[0]); else n_pass++;
        n_checks++; if (bus.fwd_data[31:0] !== 32'h5678) $display("FAIL load_use_data got %h want 00005678", bus.fwd_data[31:0]); else n_pass++;
        n_checks++; if (bus.stall_count !== 16'd1) $display("FAIL load_use_count got %0d want 1", bus.stall_count); else n_pass++;
        step();
    endtask

    task automatic test_youngest_wins();
        do_reset();
        issue(10, 1, 1'b0);
        step();
        issue(10, 1, 1'b0);
        step();
        idle();
        bus.issue_valid = 1'b1;
        read_port(0, 10);
        bus.rd_id[REG_ID_W +: REG_ID_W] = REG_ID_W'(10);  // port 1 not used
        bus.stage_data = {32'h7, 32'h9, 32'hA, 32'hB};
        #1;
        n_checks++; if (bus.fwd_data[31:0] !== 32'hB) $display("FAIL youngest_data got %h want 0000000b", bus.fwd_data[31:0]); else n_pass++;
        n_checks++; if (bus.fwd_hit !== 2'b01) $display("FAIL youngest_hit got %b want 01", bus.fwd_hit); else n_pass++;
        n_checks++; if (bus.fwd_data[63:32] !== 32'h0) $display("FAIL unused_port_data got %h want 0", bus.fwd_data[63:32]); else n_pass++;
        step();
    endtask

    task automatic test_zero_and_kill();
        do_reset();
        issue(0, 1, 1'b0);
        step();
        issue(11, 1, 1'b1);
        step();
        idle();
        bus.issue_valid = 1'b1;
        read_port(0, 0);
        read_port(1, 11);
        bus.stage_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        #1;
        n_checks++; if (bus.fwd_hit !== 2'b00) $display("FAIL zk_hit got %b want 00", bus.fwd_hit); else n_pass++;
        n_checks++; if (bus.stall !== 1'b0) $display("FAIL zk_stall got %b want 0", bus.stall); else n_pass++;
        n_checks++; if (bus.fwd_data !== '0) $display("FAIL zk_data got %h want 0", bus.fwd_data); else n_pass++;
        step();
        idle();
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (bus.retire_valid !== 1'b0) $display("FAIL zk_retire got %b want 0 (k=%0d)", bus.retire_valid, k); else n_pass++;
            step();
        end
    endtask

    task automatic test_retire_and_reset();
        do_reset();
        issue(12, 1, 1'b0);
        step();
        idle();
        for (int k = 1; k < 4; k++) begin
            #1;
            n_checks++; if (bus.retire_valid !== 1'b0) $display("FAIL retire_early got %b want 0 (k=%0d)", bus.retire_valid, k); else n_pass++;
            step();
        end
        #1;
        n_checks++; if (bus.retire_valid !== 1'b1) $display("FAIL retire_valid got %b want 1", bus.retire_valid); else n_pass++;
        n_checks++; if (bus.retire_id !== REG_ID_W'(12)) $display("FAIL retire_id got %0d want 12", bus.retire_id); else n_pass++;
        step();
        // Mid-flight reset: writer of $12 with one stall already counted
        issue(12, 2, 1'b0);
        step();
        idle();
        bus.issue_valid = 1'b1;
        read_port(0, 12);
        #1;
        n_checks++; if (bus.stall !== 1'b1) $display("FAIL rr_stall got %b want 1", bus.stall); else n_pass++;
        step();
        idle();
        #1;
        n_checks++; if (bus.stall_count !== 16'd1) $display("FAIL rr_count_pre got %0d want 1", bus.stall_count); else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 3; k < 6; k++) begin
            #1;
            n_checks++; if (bus.retire_valid !== 1'b0) $display("FAIL rr_retire got %b want 0 (cycle %0d)", bus.retire_valid, k); else n_pass++;
            n_checks++; if (bus.stall_count !== 16'd0) $display("FAIL rr_count got %0d want 0 (cycle %0d)", bus.stall_count, k); else n_pass++;
            step();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            idle();
            rst             = ($urandom_range(0, 99) == 0);
            bus.issue_valid = ($urandom_range(0, 3) != 0);
            bus.issue_wr_en = ($urandom_range(0, 3) != 0);
            bus.issue_wr_id = REG_ID_W'($urandom_range(0, 7));
            bus.issue_lat   = LAT_W'($urandom_range(1, DEPTH));
            bus.issue_kill  = ($urandom_range(0, 7) == 0);
            for (int p = 0; p < NUM_READ; p++) begin
                bus.rd_id[p*REG_ID_W +: REG_ID_W] = REG_ID_W'($urandom_range(0, 7));
                bus.rd_used[p] = ($urandom_range(0, 3) != 0);
            end
            for (int s = 0; s < DEPTH; s++) bus.stage_data[s*DATA_W +: DATA_W] = $urandom();
            #1;
            model_eval();
            n_checks++; if (bus.stall !== exp_stall) $display("FAIL rnd_stall n=%0d got %b want %b", n, bus.stall, exp_stall); else n_pass++;
            n_checks++; if (bus.fwd_hit !== exp_hit) $display("FAIL rnd_hit n=%0d got %b want %b", n, bus.fwd_hit, exp_hit); else n_pass++;
            n_checks++; if (bus.fwd_data !== exp_data) $display("FAIL rnd_data n=%0d got %h want %h", n, bus.fwd_data, exp_data); else n_pass++;
            n_checks++; if (bus.retire_valid !== exp_rv) $display("FAIL rnd_retire_valid n=%0d got %b want %b", n, bus.retire_valid, exp_rv); else n_pass++;
            n_checks++; if (bus.retire_id !== exp_rid) $display("FAIL rnd_retire_id n=%0d got %0d want %0d", n, bus.retire_id, exp_rid); else n_pass++;
            n_checks++; if (bus.stall_count !== exp_cnt) $display("FAIL rnd_count n=%0d got %0d want %0d", n, bus.stall_count, exp_cnt); else n_pass++;
            step();
        end
        rst = 1'b0;
        idle();
    endtask

    // Constant inputs: reissue $13 (lat 4) while reading it. Every group of
    // four cycles is one issue cycle followed by three stalled cycles.
    task automatic test_saturation();
        do_reset();
        issue(13, 4, 1'b0);
        read_port(0, 13);
        for (int n = 0; n < 87780; n++) begin
            if (n == 400) begin
                #1;
                n_checks++; if (bus.stall_count !== 16'd300) $display("FAIL sat_count_400 got %0d want 300", bus.stall_count); else n_pass++;
            end
            if (n == 87376) begin
                #1;
                n_checks++; if (bus.stall_count !== 16'd65532) $display("FAIL sat_count_pre got %0d want 65532", bus.stall_count); else n_pass++;
            end
            step();
        end
        #1;
        n_checks++; if (bus.stall_count !== 16'hFFFF) $display("FAIL sat_count got %h want ffff", bus.stall_count); else n_pass++;
        idle();
        step();
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        cnt_m    = 0;
        rst      = 1'b1;
        idle();
        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_youngest_wins();
        test_zero_and_kill();
        test_retire_and_reset();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

endmodule
